// File: rtl/bus_sram_responder_pkg.sv
// Shared definitions for bus responders:
// FSM state encoding and bus width.
package bus_sram_responder_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bus_sram_responder_if.sv
// CPU memory bus: request from the initiator,
// single-cycle done pulse back from the responder.
interface bus_sram_responder_if;
  import bus_sram_responder_pkg::*;

  logic [BUS_W-1:0] bus_addr;
  logic [BUS_W-1:0] bus_data;
  logic             bus_we;
  logic             bus_start;
  logic [BUS_W-1:0] bus_q;
  logic             bus_done;

  modport master (
    output bus_addr, bus_data, bus_we, bus_start,
    input  bus_q, bus_done
  );

  modport slave (
    input  bus_addr, bus_data, bus_we, bus_start,
    output bus_q, bus_done
  );

endinterface

// File: rtl/bus_sram_responder_wait_counter.sv
// 4-bit loadable down-counter with zero flag,
// used to time the wait states.
module bus_sram_responder_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/bus_sram_responder.sv
// Bus responder fronting a synchronous SRAM window
// with configurable wait states.
module bus_sram_responder
  import bus_sram_responder_pkg::*;
#(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_sram_responder_if.slave  bus,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [BUS_W-1:0]     ram_d,
  output logic                 ram_we,
  input  logic [BUS_W-1:0]     ram_q,
  output logic                 busy
);

  localparam logic [3:0] LOAD_VAL =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [BUS_W-1:0]     data_q;
  logic                 we_q;
  logic                 done_q;
  logic                 hit;
  logic                 accept;
  logic                 cnt_dec;
  logic                 cnt_zero;

  assign hit = (bus.bus_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign accept = (state == IDLE) && bus.bus_start && hit;
  assign cnt_dec = (state == WAIT) && !cnt_zero;

  bus_sram_responder_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      ram_we <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= bus.bus_addr[ADDR_BITS-1:0];
            data_q <= bus.bus_data;
            we_q   <= bus.bus_we;
            if (WAIT_STATES == 0) begin
              state  <= ACCESS;
              ram_we <= bus.bus_we;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            state  <= ACCESS;
            ram_we <= we_q;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM read data only becomes valid in DONE
  assign bus.bus_q    = (done_q && !we_q) ? ram_q : '0;
  assign bus.bus_done = done_q;
  assign ram_addr     = addr_q;
  assign ram_d        = data_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench: three responders with different
// wait states and bases, each backed by a model SRAM.
module tb_bus_sram_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bus_sram_responder_if bus_a ();
  bus_sram_responder_if bus_b ();
  bus_sram_responder_if bus_c ();

  logic [9:0]  ram_addr_a, ram_addr_b, ram_addr_c;
  logic [31:0] ram_d_a, ram_d_b, ram_d_c;
  logic        ram_we_a, ram_we_b, ram_we_c;
  logic [31:0] ram_q_a, ram_q_b;
  logic [31:0] ram_q_c = 32'h0;
  logic        busy_a, busy_b, busy_c;

  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_d = '0;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  bus_sram_responder #(
    .ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_STATES(2)
  ) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a),
    .ram_addr(ram_addr_a), .ram_d(ram_d_a), .ram_we(ram_we_a),
    .ram_q(ram_q_a), .busy(busy_a)
  );

  bus_sram_responder #(
    .ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b),
    .ram_addr(ram_addr_b), .ram_d(ram_d_b), .ram_we(ram_we_b),
    .ram_q(ram_q_b), .busy(busy_b)
  );

  bus_sram_responder #(
    .ADDR_BITS(10), .BASE_ADDR(32'h0000_0400), .WAIT_STATES(2)
  ) dut_c (
    .clk(clk), .reset(rst), .bus(bus_c),
    .ram_addr(ram_addr_c), .ram_d(ram_d_c), .ram_we(ram_we_c),
    .ram_q(ram_q_c), .busy(busy_c)
  );

  always @(posedge clk) begin
    if (pre_we) mem_a[pre_addr] <= pre_d;
    else if (ram_we_a) mem_a[ram_addr_a] <= ram_d_a;
    ram_q_a <= mem_a[ram_addr_a];
  end

  always @(posedge clk) begin
    if (ram_we_b) mem_b[ram_addr_b] <= ram_d_b;
    ram_q_b <= mem_b[ram_addr_b];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_d = d;
    pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.bus_start = 0; bus_a.bus_addr = 0; bus_a.bus_data = 0; bus_a.bus_we = 0;
    bus_b.bus_start = 0; bus_b.bus_addr = 0; bus_b.bus_data = 0; bus_b.bus_we = 0;
    bus_c.bus_start = 0; bus_c.bus_addr = 0; bus_c.bus_data = 0; bus_c.bus_we = 0;
    #2;
    checks++;
    if ({busy_a, bus_a.bus_done, ram_we_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000", {busy_a, bus_a.bus_done, ram_we_a});
    end
    checks++;
    if (bus_a.bus_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_q got %h exp 0", bus_a.bus_q);
    end
    checks++;
    if (ram_addr_a !== 10'h0 || ram_d_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_ram got %h/%h exp 0/0", ram_addr_a, ram_d_a);
    end
    preload(10'd5, 32'hDEADBEEF);
    preload(10'd7, 32'h0);
    preload(10'd8, 32'h0BADF00D);
    preload(10'd0, 32'h11111111);
    preload(10'd1, 32'h22222222);
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_ws2();
    bus_a.bus_addr = 32'd5; bus_a.bus_we = 0; bus_a.bus_data = 0;
    bus_a.bus_start = 1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      step();
      checks++;
      if (bus_a.bus_done !== (cyc == 4)) begin
        errors++;
        $display("FAIL read_done cyc %0d got %b exp %b", cyc, bus_a.bus_done, cyc == 4);
      end
      checks++;
      if (bus_a.bus_q !== ((cyc == 4) ? 32'hDEADBEEF : 32'h0)) begin
        errors++;
        $display("FAIL read_q cyc %0d got %h", cyc, bus_a.bus_q);
      end
      if (bus_a.bus_done) bus_a.bus_start = 0;
    end
    bus_a.bus_start = 0;
  endtask

  task automatic test_write_read_ws0();
    bus_b.bus_addr = 32'd3; bus_b.bus_we = 1; bus_b.bus_data = 32'h12345678;
    bus_b.bus_start = 1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      step();
      checks++;
      if (ram_we_b !== (cyc == 1)) begin
        errors++;
        $display("FAIL ws0_we cyc %0d got %b exp %b", cyc, ram_we_b, cyc == 1);
      end
      if (cyc == 1) begin
        checks++;
        if (ram_addr_b !== 10'd3) begin
          errors++;
          $display("FAIL ws0_addr got %0d exp 3", ram_addr_b);
        end
      end
      checks++;
      if (bus_b.bus_done !== (cyc == 2)) begin
        errors++;
        $display("FAIL ws0_wdone cyc %0d got %b exp %b", cyc, bus_b.bus_done, cyc == 2);
      end
      if (bus_b.bus_done) bus_b.bus_start = 0;
    end
    bus_b.bus_start = 0;
    checks++;
    if (mem_b[3] !== 32'h12345678) begin
      errors++;
      $display("FAIL ws0_mem got %h exp 12345678", mem_b[3]);
    end
    bus_b.bus_we = 0; bus_b.bus_data = 0;
    bus_b.bus_start = 1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      step();
      checks++;
      if (bus_b.bus_done !== (cyc == 2)) begin
        errors++;
        $display("FAIL ws0_rdone cyc %0d got %b exp %b", cyc, bus_b.bus_done, cyc == 2);
      end
      checks++;
      if (bus_b.bus_q !== ((cyc == 2) ? 32'h12345678 : 32'h0)) begin
        errors++;
        $display("FAIL ws0_rq cyc %0d got %h", cyc, bus_b.bus_q);
      end
      if (bus_b.bus_done) bus_b.bus_start = 0;
    end
    bus_b.bus_start = 0;
  endtask

  task automatic test_abort();
    int n = 0;
    int t = 0;
    bus_a.bus_addr = 32'd7; bus_a.bus_we = 1; bus_a.bus_data = 32'hA5A5A5A5;
    bus_a.bus_start = 1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      if (cyc == 1) begin
        bus_a.bus_start = 0;
        bus_a.bus_addr = 32'd8; bus_a.bus_we = 0; bus_a.bus_data = 32'hFFFFFFFF;
      end
      if (cyc == 3) begin
        checks++;
        if (ram_we_a !== 1'b1 || ram_addr_a !== 10'd7) begin
          errors++;
          $display("FAIL abort_access got we %b addr %0d exp 1/7", ram_we_a, ram_addr_a);
        end
      end
      if (bus_a.bus_done) begin
        n++;
        t = cyc;
      end
    end
    checks++;
    if (n !== 1 || t !== 4) begin
      errors++;
      $display("FAIL abort_done got %0d pulses last %0d exp 1 at 4", n, t);
    end
    checks++;
    if (mem_a[7] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL abort_mem7 got %h exp a5a5a5a5", mem_a[7]);
    end
    checks++;
    if (mem_a[8] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL abort_mem8 got %h exp 0badf00d", mem_a[8]);
    end
  endtask

  task automatic test_miss();
    bus_c.bus_addr = 32'h0000_0010; bus_c.bus_we = 1; bus_c.bus_data = 32'h1;
    bus_c.bus_start = 1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      checks++;
      if ({busy_c, bus_c.bus_done, ram_we_c} !== 3'b000) begin
        errors++;
        $display("FAIL miss cyc %0d got %b exp 000", cyc, {busy_c, bus_c.bus_done, ram_we_c});
      end
    end
    bus_c.bus_start = 0;
    step();
    bus_c.bus_addr = 32'h0000_0405; bus_c.bus_we = 0;
    bus_c.bus_start = 1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      step();
      if (cyc == 1) begin
        checks++;
        if (busy_c !== 1'b1) begin
          errors++;
          $display("FAIL hit_busy got %b exp 1", busy_c);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (ram_addr_c !== 10'd5) begin
          errors++;
          $display("FAIL hit_addr got %0d exp 5", ram_addr_c);
        end
      end
      checks++;
      if (bus_c.bus_done !== (cyc == 4)) begin
        errors++;
        $display("FAIL hit_done cyc %0d got %b exp %b", cyc, bus_c.bus_done, cyc == 4);
      end
      if (bus_c.bus_done) bus_c.bus_start = 0;
    end
    bus_c.bus_start = 0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int t [2] = '{0, 0};
    logic [31:0] d [2] = '{32'h0, 32'h0};
    logic relaunch = 1'b0;
    bus_a.bus_addr = 32'd0; bus_a.bus_we = 0; bus_a.bus_data = 0;
    bus_a.bus_start = 1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (relaunch) begin
        bus_a.bus_addr = 32'd1;
        bus_a.bus_start = 1;
        relaunch = 1'b0;
      end
      if (bus_a.bus_done) begin
        if (n < 2) begin
          t[n] = cyc;
          d[n] = bus_a.bus_q;
        end
        n++;
        bus_a.bus_start = 0;
        if (n == 1) relaunch = 1'b1;
      end
    end
    bus_a.bus_start = 0;
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 2", n);
    end
    checks++;
    if (t[0] !== 4 || t[1] - t[0] !== 5) begin
      errors++;
      $display("FAIL b2b_timing got %0d,%0d exp 4,9", t[0], t[1]);
    end
    checks++;
    if (d[0] !== 32'h11111111 || d[1] !== 32'h22222222) begin
      errors++;
      $display("FAIL b2b_data got %h,%h exp 11111111,22222222", d[0], d[1]);
    end
  endtask

  task automatic test_async_reset();
    bus_a.bus_addr = 32'd9; bus_a.bus_we = 1; bus_a.bus_data = 32'h99;
    bus_a.bus_start = 1;
    for (int cyc = 1; cyc <= 3; cyc++) step();
    checks++;
    if (ram_we_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got we %b busy %b exp 1/1", ram_we_a, busy_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_a, bus_a.bus_done, ram_we_a} !== 3'b000) begin
      errors++;
      $display("FAIL areset_now got %b exp 000", {busy_a, bus_a.bus_done, ram_we_a});
    end
    checks++;
    if (ram_addr_a !== 10'd0) begin
      errors++;
      $display("FAIL areset_addr got %0d exp 0", ram_addr_a);
    end
    bus_a.bus_start = 0;
    step();
    step();
    rst = 1'b0;
    step();
    test_read_ws2();
  endtask

  initial begin
    test_reset();
    test_read_ws2();
    test_write_read_ws0();
    test_abort();
    test_miss();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_sram_responder.md
Name: bus_sram_responder

Overview:
- Responder (target) side of the CPU memory bus (bus_addr / bus_data / bus_we / bus_start / bus_q / bus_done).
- Accepts one request at a time from an initiator such as the instruction or data memory stage.
- Inserts a configurable number of wait states and performs the access on a synchronous single-port SRAM with 1-cycle registered read.
- Answers with a single-cycle bus_done pulse; read data is valid only in that cycle.

Parameters:
- ADDR_BITS, 10, word-address width of the SRAM window (window = 2**ADDR_BITS words).
- BASE_ADDR, 32'h0000_0000, window base; must be aligned to 2**ADDR_BITS.
- WAIT_STATES, 2, extra cycles inserted between accept and SRAM access; 0..15 legal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_addr  in  32  word address from initiator.
- bus_data  in  32  write data.
- bus_we  in  1  1 = write, 0 = read.
- bus_start  in  1  request; held high by initiator until it sees bus_done.
- bus_q  out  32  read data; valid only while bus_done = 1.
- bus_done  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_BITS  SRAM address.
- ram_d  out  32  SRAM write data.
- ram_we  out  1  SRAM write enable.
- ram_q  in  32  SRAM read data, valid the cycle after ram_addr is presented with ram_we = 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state):
  - state = IDLE; bus_done = 0; bus_q = 0; ram_we = 0; ram_addr = 0; ram_d = 0; busy = 0.
  - Wait counter = 0; latched request cleared.
- Hit: bus_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS].
  - Misses are ignored and the FSM stays in IDLE; another responder owns that address.
- IDLE: if bus_start and hit, latch addr[ADDR_BITS-1:0], data and we.
  - Go to WAIT if WAIT_STATES > 0; otherwise go to ACCESS.
  - Counter is loaded with WAIT_STATES-1.
- WAIT: decrement the counter each cycle; at 0, go to ACCESS. Bus inputs are not sampled.
- ACCESS (1 cycle):
  - ram_addr and ram_d are driven from the latches.
  - ram_we = latched we, high for exactly this cycle.
  - Next state DONE.
- DONE (1 cycle):
  - bus_done = 1.
  - bus_q = ram_q for a read; bus_q = 0 for a write.
  - Next state IDLE.
- Outputs outside DONE: bus_done = 0, bus_q = 0. ram_we = 0 outside ACCESS.
- Latency: a request accepted at edge E gives bus_done high in cycle E + WAIT_STATES + 2 (counted in cycles after E).
- Back-to-back requests:
  - The initiator drops bus_start combinationally in the DONE cycle.
  - A new bus_start is sampled in IDLE on the next cycle, so the minimum period is WAIT_STATES + 3 cycles.
  - bus_start high during DONE is never accepted.
- Initiator abort (bus_start drops while busy):
  - The transaction still runs to completion; writes are committed and bus_done still pulses.
  - The initiator discards the result.
  - No cancel path exists.
- Input changes while busy: bus_addr, bus_data and bus_we changes have no effect; only the latched values are used.
- Address arithmetic:
  - Only the low ADDR_BITS bits reach the SRAM.
  - No wrap or overflow handling is needed, because misses are filtered.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, DONE=2'd3) and bus width constant BUS_W=32, reusable by other bus responders.
- Optional sub-module wait_counter: 4-bit loadable down-counter with a zero flag.
- Everything else is inline.

Test Plan:
- Read, WAIT_STATES=2: SRAM preloaded with word 5 = 32'hDEADBEEF; bus_start with addr 5, we=0 at edge E -> bus_done high only in cycle E+4 with bus_q = 32'hDEADBEEF; bus_q = 0 in all other cycles.
- Write then read, WAIT_STATES=0: write 32'h12345678 to addr 3 -> ram_we high exactly 1 cycle with ram_addr=3, bus_done at E+2; then read addr 3 -> bus_q = 32'h12345678.
- Abort mid-wait: write 32'hA5A5A5A5 to addr 7, drop bus_start 1 cycle after accept -> bus_done still pulses once; SRAM word 7 = 32'hA5A5A5A5; no second transaction.
- Miss: BASE_ADDR = 32'h0000_0400, request addr 32'h0000_0010 held 10 cycles -> busy = 0, bus_done = 0 and ram_we = 0 throughout.
- Back-to-back reads at addr 0 then 1 with the initiator re-asserting start the cycle after done -> two done pulses exactly WAIT_STATES+3 cycles apart with the correct data.
- Async reset asserted mid-ACCESS of a write -> bus_done, ram_we and busy are 0 immediately, without waiting for a clock edge; after release the FSM is in IDLE and a new read completes normally.
